// File: rtl/err_inj_pkg.sv
// Shared types and LFSR polynomial for the channel-error injector.
// Galois right-shift step used by err_lfsr32 (random mode, ERR_RANDOM_EN).
package err_inj_pkg;

    typedef enum logic [1:0] {IDLE, GAP, BURST, DONE} state_t;

    typedef enum logic [1:0] {MODE_OFF, MODE_PERIODIC, MODE_ONESHOT, MODE_RANDOM} mode_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/err_lfsr32.sv
// 32-bit Galois LFSR with seed load and step enable; exposes the low byte only.
module err_lfsr32
    import err_inj_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE11234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_step,
    output logic [7:0] o_rnd
);

    logic [31:0] r_state;

    // Load and step together means the arm-cycle symbol consumed the seed value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEED;
        end else if (i_load && i_step) begin
            r_state <= lfsr_next(SEED);
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_rnd = r_state[7:0];

endmodule

// File: rtl/chan_err_injector.sv
// Channel-error injector: registered symbol path with periodic / one-shot burst corruption.
// Random mode (LFSR driven) is built only when ERR_RANDOM_EN is defined.
module chan_err_injector
    import err_inj_pkg::*;
#(
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] LFSR_SEED = 32'hACE11234
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_burst_i,
    input  logic [SYM_W-1:0] cfg_mask_i,
    input  logic [7:0]       cfg_thresh_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic [SYM_W-1:0] err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] word_ct_o,
    output logic [CNT_W-1:0] inj_ct_o,
    output logic [CNT_W-1:0] bit_ct_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [SYM_W-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < SYM_W; i++) begin
            c = c + CNT_W'(m[i]);
        end
        popcount = c;
    endfunction

    state_t           r_state;
    mode_t            r_mode;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_burst;
    logic [SYM_W-1:0] r_mask;
    logic [CNT_W-1:0] r_gap_ct;
    logic [CNT_W-1:0] r_burst_ct;
    logic [CNT_W-1:0] r_word_ct;
    logic [CNT_W-1:0] r_inj_ct;
    logic [CNT_W-1:0] r_bit_ct;
    logic             r_valid;
    logic [SYM_W-1:0] r_sym;
    logic [SYM_W-1:0] r_err;

    // Effective view of config/state for this cycle: arm overrides the registered copies.
    mode_t            w_mode;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_burst;
    logic [SYM_W-1:0] w_mask;
    state_t           w_state_eff;
    logic [CNT_W-1:0] w_gap_eff;
    logic [CNT_W-1:0] w_burst_eff;
    logic [CNT_W-1:0] w_word_eff;
    logic [CNT_W-1:0] w_inj_eff;
    logic [CNT_W-1:0] w_bit_eff;
    logic             w_rand_mode;
    logic             w_run_mode;

    state_t           w_state_d;
    logic [CNT_W-1:0] w_gap_d;
    logic [CNT_W-1:0] w_burst_d;
    logic [CNT_W-1:0] w_word_d;
    logic [CNT_W-1:0] w_inj_d;
    logic [CNT_W-1:0] w_bit_d;
    logic             w_corrupt;
    logic             w_finish;
    logic             w_window_hit;
    logic [SYM_W-1:0] w_err;

`ifdef ERR_RANDOM_EN
    logic [7:0] r_thresh;
    logic [7:0] w_thresh;
    logic [7:0] w_lfsr_rnd;
    logic [7:0] w_rnd;
    logic       w_lfsr_step;

    assign w_rand_mode = (w_mode == MODE_RANDOM);
    assign w_thresh    = arm_i ? cfg_thresh_i : r_thresh;
    assign w_rnd       = arm_i ? LFSR_SEED[7:0] : w_lfsr_rnd;
    assign w_lfsr_step = valid_i && (w_state_eff == GAP) && w_rand_mode;

    err_lfsr32 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_load (arm_i),
        .i_step (w_lfsr_step),
        .o_rnd  (w_lfsr_rnd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_thresh <= '0;
        end else if (arm_i) begin
            r_thresh <= cfg_thresh_i;
        end
    end
`else
    logic w_unused_rand;
    assign w_rand_mode   = 1'b0;
    assign w_unused_rand = ^{cfg_thresh_i, LFSR_SEED};
`endif

    always_comb begin
        w_mode      = arm_i ? mode_t'(cfg_mode_i) : r_mode;
        w_period    = arm_i ? cfg_period_i : r_period;
        w_burst     = arm_i ? cfg_burst_i : r_burst;
        w_mask      = arm_i ? cfg_mask_i : r_mask;
        w_run_mode  = (w_mode == MODE_PERIODIC) || (w_mode == MODE_ONESHOT) || w_rand_mode;
        w_state_eff = arm_i ? (w_run_mode ? GAP : IDLE) : r_state;
        w_gap_eff   = arm_i ? '0 : r_gap_ct;
        w_burst_eff = arm_i ? '0 : r_burst_ct;
        w_word_eff  = arm_i ? '0 : r_word_ct;
        w_inj_eff   = arm_i ? '0 : r_inj_ct;
        w_bit_eff   = arm_i ? '0 : r_bit_ct;
    end

    always_comb begin
        w_state_d    = w_state_eff;
        w_gap_d      = w_gap_eff;
        w_burst_d    = w_burst_eff;
        w_corrupt    = 1'b0;
        w_finish     = 1'b0;
        w_window_hit = 1'b0;
        w_word_d     = w_word_eff;
        if (valid_i) begin
            w_word_d = sat_add(w_word_eff, CNT_ONE);
            unique case (w_state_eff)
                GAP: begin
                    if (w_rand_mode) begin
`ifdef ERR_RANDOM_EN
                        w_corrupt = (w_rnd < w_thresh);
`endif
                    end else if (w_gap_eff < w_period) begin
                        w_gap_d = w_gap_eff + CNT_ONE;
                    end else if (w_burst == '0) begin
                        if (w_mode == MODE_ONESHOT) begin
                            w_state_d = DONE;
                        end
                    end else begin
                        w_corrupt = 1'b1;
                        if (w_burst == CNT_ONE) begin
                            w_finish = 1'b1;
                        end else begin
                            w_state_d = BURST;
                            w_burst_d = CNT_ONE;
                        end
                    end
                end
                BURST: begin
                    w_corrupt = 1'b1;
                    if (w_burst_eff + CNT_ONE == w_burst) begin
                        w_finish = 1'b1;
                    end else begin
                        w_burst_d = w_burst_eff + CNT_ONE;
                    end
                end
                default: ;
            endcase
            if (w_finish) begin
                w_burst_d = '0;
                if (w_mode == MODE_ONESHOT) begin
                    w_state_d = DONE;
                end else begin
                    w_state_d = GAP;
                    w_gap_d   = '0;
                end
            end
            // The last in-window symbol may still be corrupted; the run stops right after it.
            if ((MAX_WORDS != 0) && ((w_state_eff == GAP) || (w_state_eff == BURST)) &&
                (32'(w_word_d) >= MAX_WORDS)) begin
                w_window_hit = 1'b1;
                w_state_d    = DONE;
            end
        end
        w_err   = w_corrupt ? w_mask : '0;
        w_inj_d = (w_corrupt && (w_mask != '0)) ? sat_add(w_inj_eff, CNT_ONE) : w_inj_eff;
        w_bit_d = w_corrupt ? sat_add(w_bit_eff, popcount(w_mask)) : w_bit_eff;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_mode     <= MODE_OFF;
            r_period   <= '0;
            r_burst    <= '0;
            r_mask     <= '0;
            r_gap_ct   <= '0;
            r_burst_ct <= '0;
            r_word_ct  <= '0;
            r_inj_ct   <= '0;
            r_bit_ct   <= '0;
            r_valid    <= 1'b0;
            r_sym      <= '0;
            r_err      <= '0;
        end else begin
            if (arm_i) begin
                r_mode   <= mode_t'(cfg_mode_i);
                r_period <= cfg_period_i;
                r_burst  <= cfg_burst_i;
                r_mask   <= cfg_mask_i;
            end
            r_state    <= w_state_d;
            r_gap_ct   <= w_gap_d;
            r_burst_ct <= w_window_hit ? '0 : w_burst_d;
            r_word_ct  <= w_word_d;
            r_inj_ct   <= w_inj_d;
            r_bit_ct   <= w_bit_d;
            r_valid    <= valid_i;
            r_err      <= w_err;
            if (valid_i) begin
                r_sym <= sym_i ^ w_err;
            end
        end
    end

    assign valid_o   = r_valid;
    assign sym_o     = r_sym;
    assign err_o     = r_err;
    assign busy_o    = (r_state == GAP) || (r_state == BURST);
    assign word_ct_o = r_word_ct;
    assign inj_ct_o  = r_inj_ct;
    assign bit_ct_o  = r_bit_ct;

endmodule

// File: tb/tb_chan_err_injector.sv
// Self-checking bench for chan_err_injector: directed scenarios plus randomized runs,
// checked against an index-arithmetic reference model.
module tb_chan_err_injector;

    localparam int          SYM_W = 2;
    localparam int          CNT_W = 16;
    localparam int          MAXW  = 256;
    localparam logic [31:0] SEED  = 32'hACE11234;
    localparam logic [31:0] POLY  = 32'h80200003;
`ifdef ERR_RANDOM_EN
    localparam bit RAND_EN = 1'b1;
`else
    localparam bit RAND_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] burst;
    logic [SYM_W-1:0] mask;
    logic [7:0]       thresh;
    logic             valid;
    logic [SYM_W-1:0] sym;
    logic             valid_o;
    logic [SYM_W-1:0] sym_o;
    logic [SYM_W-1:0] err_o;
    logic             busy_o;
    logic [CNT_W-1:0] word_ct_o;
    logic [CNT_W-1:0] inj_ct_o;
    logic [CNT_W-1:0] bit_ct_o;

    chan_err_injector #(
        .SYM_W     (SYM_W),
        .CNT_W     (CNT_W),
        .MAX_WORDS (MAXW),
        .LFSR_SEED (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm_i        (arm),
        .cfg_mode_i   (mode),
        .cfg_period_i (period),
        .cfg_burst_i  (burst),
        .cfg_mask_i   (mask),
        .cfg_thresh_i (thresh),
        .valid_i      (valid),
        .sym_i        (sym),
        .valid_o      (valid_o),
        .sym_o        (sym_o),
        .err_o        (err_o),
        .busy_o       (busy_o),
        .word_ct_o    (word_ct_o),
        .inj_ct_o     (inj_ct_o),
        .bit_ct_o     (bit_ct_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: corruption decided purely from the symbol index since arm.
    bit          m_active;
    int          m_mode;
    int          m_period;
    int          m_burst;
    logic [1:0]  m_mask;
    logic [7:0]  m_thresh;
    int          m_n;
    int          m_inj;
    int          m_bits;
    logic [31:0] m_lfsr;
    logic        e_valid;
    logic [1:0]  e_sym;
    logic [1:0]  e_err;

    function automatic bit index_hit(input int n);
        if (n >= MAXW || m_burst == 0) return 1'b0;
        if (m_mode == 1) return (n % (m_period + m_burst)) >= m_period;
        if (m_mode == 2) return (n >= m_period) && (n < m_period + m_burst);
        return 1'b0;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_mode   = 0;
        m_period = 0;
        m_burst  = 0;
        m_mask   = '0;
        m_thresh = '0;
        m_n      = 0;
        m_inj    = 0;
        m_bits   = 0;
        m_lfsr   = SEED;
        e_valid  = 1'b0;
        e_sym    = '0;
        e_err    = '0;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
        check_eq({tag, ".sym"}, 32'(sym_o), 32'(e_sym));
        check_eq({tag, ".err"}, 32'(err_o), 32'(e_err));
        check_eq({tag, ".word"}, 32'(word_ct_o), sat16(m_n));
        check_eq({tag, ".inj"}, 32'(inj_ct_o), sat16(m_inj));
        check_eq({tag, ".bits"}, 32'(bit_ct_o), sat16(m_bits));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input string tag, input bit a, input bit v, input logic [1:0] s);
        bit hit;
        arm   = a;
        valid = v;
        sym   = s;
        if (a) begin
            m_mode   = int'(mode);
            m_period = int'(period);
            m_burst  = int'(burst);
            m_mask   = mask;
            m_thresh = thresh;
            m_n      = 0;
            m_inj    = 0;
            m_bits   = 0;
            m_lfsr   = SEED;
            m_active = (mode == 2'd1) || (mode == 2'd2) || (RAND_EN && mode == 2'd3);
        end
        hit = 1'b0;
        if (v) begin
            if (m_active && m_n < MAXW) begin
                if (m_mode == 3) begin
                    hit    = m_lfsr[7:0] < m_thresh;
                    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'h0);
                end else begin
                    hit = index_hit(m_n);
                end
            end
            m_n++;
        end
        e_err   = hit ? m_mask : 2'b00;
        e_valid = v;
        if (v) e_sym = s ^ e_err;
        if (hit) begin
            if (m_mask != 2'b00) m_inj++;
            m_bits += $countones(m_mask);
        end
        @(posedge clk);
        #1;
        arm = 1'b0;
        compare_all(tag);
    endtask

    task automatic arm_run(input string tag, input logic [1:0] md, input int per,
                           input int bur, input logic [1:0] msk, input logic [7:0] th);
        mode   = md;
        period = CNT_W'(per);
        burst  = CNT_W'(bur);
        mask   = msk;
        thresh = th;
        cycle(tag, 1'b1, 1'b1, 2'($urandom));
    endtask

    initial begin
        rst    = 1'b0;
        arm    = 1'b0;
        mode   = '0;
        period = '0;
        burst  = '0;
        mask   = '0;
        thresh = '0;
        valid  = 1'b0;
        sym    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check_eq("reset.busy", 32'(busy_o), 32'd0);
        rst = 1'b1;

        // Scenario 1: periodic, 20 contiguous symbols
        arm_run("s1", 2'd1, 4, 3, 2'b10, 8'h00);
        check_eq("s1.busy", 32'(busy_o), 32'd1);
        for (int i = 1; i < 20; i++) cycle("s1", 1'b0, 1'b1, 2'($urandom));
        check_eq("s1.inj_total", 32'(inj_ct_o), 32'd8);

        // Scenario 2: one-shot burst at start
        arm_run("s2", 2'd2, 0, 5, 2'b11, 8'h00);
        for (int i = 1; i < 10; i++) cycle("s2", 1'b0, 1'b1, 2'($urandom));
        check_eq("s2.inj_total", 32'(inj_ct_o), 32'd5);
        check_eq("s2.bit_total", 32'(bit_ct_o), 32'd10);
        check_eq("s2.busy_done", 32'(busy_o), 32'd0);

        // Scenario 3: window truncation over 300 symbols
        arm_run("s3", 2'd1, 31, 5, 2'b01, 8'h00);
        for (int i = 1; i < 300; i++) cycle("s3", 1'b0, 1'b1, 2'($urandom));
        check_eq("s3.busy_done", 32'(busy_o), 32'd0);

        // Scenario 4: valid toggling every cycle
        arm_run("s4", 2'd1, 4, 3, 2'b10, 8'h00);
        for (int i = 1; i < 40; i++) cycle("s4", 1'b0, (i % 2) == 0, 2'($urandom));
        check_eq("s4.inj_total", 32'(inj_ct_o), 32'd8);

        // Scenario 5: re-arm mid-burst, then async reset mid-run
        arm_run("s5a", 2'd1, 2, 6, 2'b11, 8'h00);
        for (int i = 1; i < 5; i++) cycle("s5a", 1'b0, 1'b1, 2'($urandom));
        arm_run("s5b", 2'd1, 3, 2, 2'b01, 8'h00);
        for (int i = 1; i < 12; i++) cycle("s5b", 1'b0, 1'b1, 2'($urandom));
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("s5rst");
        check_eq("s5rst.busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cycle("s5post", 1'b0, 1'b1, 2'($urandom));

        // Scenario 6: random mode with maximal threshold
        arm_run("s6", 2'd3, 0, 0, 2'b11, 8'hFF);
        for (int i = 1; i < 40; i++) cycle("s6", 1'b0, 1'b1, 2'($urandom));
        if (!RAND_EN) check_eq("s6.inj_off", 32'(inj_ct_o), 32'd0);

        // Randomized configurations and valid patterns
        for (int r = 0; r < 12; r++) begin
            arm_run("rnd", 2'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)), 2'($urandom), 8'($urandom));
            for (int i = 0; i < 45; i++)
                cycle("rnd", 1'b0, $urandom_range(0, 3) != 0, 2'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
